// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch predictor: 2-bit counter encoding
// and the saturating counter update rule.
package branch_pkg;

   typedef logic [1:0] bht_cnt_t;

   localparam bht_cnt_t BHT_SNT = 2'd0;
   localparam bht_cnt_t BHT_WNT = 2'd1;
   localparam bht_cnt_t BHT_WT  = 2'd2;
   localparam bht_cnt_t BHT_ST  = 2'd3;

   function automatic bht_cnt_t sat_update(input bht_cnt_t cnt, input logic taken);
      bht_cnt_t res;
      res = cnt;
      if (taken) begin
         if (cnt != BHT_ST) res = cnt + 2'd1;
      end else begin
         if (cnt != BHT_SNT) res = cnt - 2'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational read port (ID lookup) and one clocked write port (EX update).
module bht_table
   import branch_pkg::*;
#(
   parameter int ENTRIES = 64,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx_i,
   output bht_cnt_t         rd_cnt_o,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic             wr_taken_i
);

   bht_cnt_t cnt_q [ENTRIES];
   bht_cnt_t wr_cnt_d;

   // No bypass: a same-cycle read at the write index returns the old counter.
   assign rd_cnt_o = cnt_q[rd_idx_i];
   assign wr_cnt_d = sat_update(cnt_q[wr_idx_i], wr_taken_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= BHT_WNT;
      end else if (wr_en_i) begin
         cnt_q[wr_idx_i] <= wr_cnt_d;
      end
   end

endmodule

// File: rtl/branch_ctrl.sv
// Branch prediction and redirect controller: predicts in ID from the BHT,
// resolves in EX, drives fetch redirects/flushes and keeps branch statistics.
module branch_ctrl
   import branch_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic            id_branch,
   input  logic            id_stall,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_imm,
   output logic            id_pred_taken,
   input  logic            ex_valid,
   input  logic            ex_branch,
   input  logic            ex_pred_taken,
   input  logic            ex_take_branch,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_target,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush_if_id,
   output logic            flush_id_ex,
   output logic [31:0]     branch_cnt,
   output logic [31:0]     mispredict_cnt
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   logic [IDX_W-1:0] id_idx;
   logic [IDX_W-1:0] ex_idx;
   bht_cnt_t         id_cnt;
   logic             ex_resolve;
   logic             mispredict;
   logic             id_redirect;
   logic [31:0]      branch_cnt_q,     branch_cnt_d;
   logic [31:0]      mispredict_cnt_q, mispredict_cnt_d;

   assign id_idx = id_pc[IDX_W+1:2];
   assign ex_idx = ex_pc[IDX_W+1:2];

   bht_table #(
      .ENTRIES (BHT_ENTRIES),
      .IDX_W   (IDX_W)
   ) u_bht (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_idx_i   (id_idx),
      .rd_cnt_o   (id_cnt),
      .wr_en_i    (ex_resolve),
      .wr_idx_i   (ex_idx),
      .wr_taken_i (ex_take_branch)
   );

   assign id_pred_taken = id_valid & id_branch & id_cnt[1];
   assign ex_resolve    = ex_valid & ex_branch;
   assign mispredict    = ex_resolve & (ex_take_branch ^ ex_pred_taken);
   // A stalled ID instruction redirects only in the cycle it leaves ID.
   assign id_redirect   = id_pred_taken & ~id_stall;

   always_comb begin
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      flush_if_id    = 1'b0;
      flush_id_ex    = 1'b0;
      // The EX mispredict wins; flushing ID/EX drops the younger ID prediction.
      if (mispredict) begin
         redirect_valid = 1'b1;
         redirect_pc    = ex_take_branch ? ex_target : ex_pc + XLEN'(4);
         flush_if_id    = 1'b1;
         flush_id_ex    = 1'b1;
      end else if (id_redirect) begin
         redirect_valid = 1'b1;
         redirect_pc    = id_pc + id_imm;
         flush_if_id    = 1'b1;
      end
   end

   always_comb begin
      branch_cnt_d     = branch_cnt_q;
      mispredict_cnt_d = mispredict_cnt_q;
      if (ex_resolve && branch_cnt_q != 32'hFFFF_FFFF)
         branch_cnt_d = branch_cnt_q + 32'd1;
      if (mispredict && mispredict_cnt_q != 32'hFFFF_FFFF)
         mispredict_cnt_d = mispredict_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         branch_cnt_q     <= branch_cnt_d;
         mispredict_cnt_q <= mispredict_cnt_d;
      end
   end

   assign branch_cnt     = branch_cnt_q;
   assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed testbench for branch_ctrl: prediction, redirect priority, stall,
// table update ordering, saturation and asynchronous reset.
module tb_branch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid, id_branch, id_stall;
   logic [31:0] id_pc, id_imm;
   logic        id_pred_taken;
   logic        ex_valid, ex_branch, ex_pred_taken, ex_take_branch;
   logic [31:0] ex_pc, ex_target;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush_if_id, flush_id_ex;
   logic [31:0] branch_cnt, mispredict_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   branch_ctrl #(.XLEN(32), .BHT_ENTRIES(64)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .id_valid       (id_valid),
      .id_branch      (id_branch),
      .id_stall       (id_stall),
      .id_pc          (id_pc),
      .id_imm         (id_imm),
      .id_pred_taken  (id_pred_taken),
      .ex_valid       (ex_valid),
      .ex_branch      (ex_branch),
      .ex_pred_taken  (ex_pred_taken),
      .ex_take_branch (ex_take_branch),
      .ex_pc          (ex_pc),
      .ex_target      (ex_target),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush_if_id    (flush_if_id),
      .flush_id_ex    (flush_id_ex),
      .branch_cnt     (branch_cnt),
      .mispredict_cnt (mispredict_cnt)
   );

   task automatic idle_inputs();
      id_valid = 0; id_branch = 0; id_stall = 0; id_pc = 0; id_imm = 0;
      ex_valid = 0; ex_branch = 0; ex_pred_taken = 0; ex_take_branch = 0;
      ex_pc = 0; ex_target = 0;
   endtask

   task automatic drive_id(input logic [31:0] pc, input logic [31:0] imm, input logic stall);
      id_valid = 1; id_branch = 1; id_pc = pc; id_imm = imm; id_stall = stall;
   endtask

   task automatic drive_ex(input logic [31:0] pc, input logic [31:0] tgt,
                           input logic pred, input logic take);
      ex_valid = 1; ex_branch = 1; ex_pc = pc; ex_target = tgt;
      ex_pred_taken = pred; ex_take_branch = take;
   endtask

   task automatic test_reset();
      rst_n = 0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      drive_id(32'h100, 32'h40, 0);
      #1;
      checks++; if (id_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred got=%b exp=0", id_pred_taken); end
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_redirect got=%b exp=0", redirect_valid); end
      checks++; if (flush_if_id !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", flush_if_id); end
      checks++; if (branch_cnt !== 32'd0) begin errors++; $display("FAIL reset_branch_cnt got=%h exp=0", branch_cnt); end
      checks++; if (mispredict_cnt !== 32'd0) begin errors++; $display("FAIL reset_misp_cnt got=%h exp=0", mispredict_cnt); end
   endtask

   // Entry 0 (PC 0x100) trained 1 -> 2 -> 3 by two taken mispredicts.
   task automatic test_train();
      for (int n = 0; n < 2; n++) begin
         @(negedge clk);
         idle_inputs();
         drive_ex(32'h100, 32'h140, 0, 1);
         #1;
         checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL train_redirect[%0d] got=%b exp=1", n, redirect_valid); end
         checks++; if (redirect_pc !== 32'h140) begin errors++; $display("FAIL train_pc[%0d] got=%h exp=00000140", n, redirect_pc); end
         checks++; if (flush_id_ex !== 1'b1) begin errors++; $display("FAIL train_flush_id_ex[%0d] got=%b exp=1", n, flush_id_ex); end
      end
      @(negedge clk);
      idle_inputs();
      drive_id(32'h100, 32'h40, 0);
      #1;
      checks++; if (id_pred_taken !== 1'b1) begin errors++; $display("FAIL id_pred got=%b exp=1", id_pred_taken); end
      checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL id_redirect got=%b exp=1", redirect_valid); end
      checks++; if (redirect_pc !== 32'h140) begin errors++; $display("FAIL id_redirect_pc got=%h exp=00000140", redirect_pc); end
      checks++; if (flush_if_id !== 1'b1) begin errors++; $display("FAIL id_flush_if_id got=%b exp=1", flush_if_id); end
      checks++; if (flush_id_ex !== 1'b0) begin errors++; $display("FAIL id_flush_id_ex got=%b exp=0", flush_id_ex); end
      checks++; if (branch_cnt !== 32'd2 || mispredict_cnt !== 32'd2) begin errors++; $display("FAIL train_counts got=%0d/%0d exp=2/2", branch_cnt, mispredict_cnt); end
   endtask

   // EX not-taken mispredict at 0x200 (also index 0: 3 -> 2) overrides the ID redirect.
   task automatic test_priority();
      @(negedge clk);
      idle_inputs();
      drive_id(32'h100, 32'h40, 0);
      drive_ex(32'h200, 32'h300, 1, 0);
      #1;
      checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL prio_redirect got=%b exp=1", redirect_valid); end
      checks++; if (redirect_pc !== 32'h204) begin errors++; $display("FAIL prio_pc got=%h exp=00000204", redirect_pc); end
      checks++; if (flush_if_id !== 1'b1 || flush_id_ex !== 1'b1) begin errors++; $display("FAIL prio_flush got=%b%b exp=11", flush_if_id, flush_id_ex); end
   endtask

   task automatic test_stall();
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         idle_inputs();
         drive_id(32'h100, 32'h40, 1);
         #1;
         checks++; if (id_pred_taken !== 1'b1) begin errors++; $display("FAIL stall_pred[%0d] got=%b exp=1", n, id_pred_taken); end
         checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL stall_redirect[%0d] got=%b exp=0", n, redirect_valid); end
      end
      @(negedge clk);
      drive_id(32'h100, 32'h40, 0);
      #1;
      checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h140) begin errors++; $display("FAIL stall_release got=%b/%h exp=1/00000140", redirect_valid, redirect_pc); end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL stall_once got=%b exp=0", redirect_valid); end
   endtask

   // Entry 1 (PC 0x104): old-value read, saturation at 3; entry 2 (PC 0x108): floor at 0.
   task automatic test_same_index();
      @(negedge clk);
      idle_inputs();
      drive_id(32'h104, 32'h20, 0);
      drive_ex(32'h104, 32'h124, 0, 1);
      #1;
      checks++; if (id_pred_taken !== 1'b0) begin errors++; $display("FAIL same_idx_old got=%b exp=0", id_pred_taken); end
      @(negedge clk);
      idle_inputs();
      drive_id(32'h104, 32'h20, 0);
      #1;
      checks++; if (id_pred_taken !== 1'b1) begin errors++; $display("FAIL same_idx_new got=%b exp=1", id_pred_taken); end
      for (int n = 0; n < 2; n++) begin
         @(negedge clk);
         idle_inputs();
         drive_ex(32'h104, 32'h124, 1, 1);
         #1;
         checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL correct_pred_redirect[%0d] got=%b exp=0", n, redirect_valid); end
      end
      for (int n = 0; n < 2; n++) begin
         @(negedge clk);
         idle_inputs();
         drive_ex(32'h104, 32'h124, 1, 0);
      end
      @(negedge clk);
      idle_inputs();
      drive_id(32'h104, 32'h20, 0);
      #1;
      checks++; if (id_pred_taken !== 1'b0) begin errors++; $display("FAIL sat_high got=%b exp=0", id_pred_taken); end
      for (int n = 0; n < 2; n++) begin
         @(negedge clk);
         idle_inputs();
         drive_ex(32'h108, 32'h200, 0, 0);
      end
      @(negedge clk);
      idle_inputs();
      drive_id(32'h108, 32'h20, 0);
      #1;
      checks++; if (id_pred_taken !== 1'b0) begin errors++; $display("FAIL sat_low got=%b exp=0", id_pred_taken); end
      checks++; if (branch_cnt !== 32'd10 || mispredict_cnt !== 32'd6) begin errors++; $display("FAIL counts got=%0d/%0d exp=10/6", branch_cnt, mispredict_cnt); end
   endtask

   task automatic test_non_branch();
      @(negedge clk);
      idle_inputs();
      ex_valid = 1; ex_branch = 0; ex_pred_taken = 0; ex_take_branch = 1;
      ex_pc = 32'h104; ex_target = 32'h500;
      #1;
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL nonbranch_redirect got=%b exp=0", redirect_valid); end
      @(negedge clk);
      idle_inputs();
      ex_valid = 0; ex_branch = 1; ex_pred_taken = 0; ex_take_branch = 1;
      #1;
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL invalid_ex_redirect got=%b exp=0", redirect_valid); end
      @(negedge clk);
      idle_inputs();
      drive_id(32'h104, 32'h20, 0);
      #1;
      checks++; if (id_pred_taken !== 1'b0) begin errors++; $display("FAIL nonbranch_noupdate got=%b exp=0", id_pred_taken); end
      checks++; if (branch_cnt !== 32'd10 || mispredict_cnt !== 32'd6) begin errors++; $display("FAIL nonbranch_counts got=%0d/%0d exp=10/6", branch_cnt, mispredict_cnt); end
   endtask

   task automatic test_stat_saturation();
      @(negedge clk);
      idle_inputs();
      force dut.branch_cnt_q = 32'hFFFF_FFFE;
      force dut.mispredict_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.branch_cnt_q;
      release dut.mispredict_cnt_q;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         idle_inputs();
         drive_ex(32'h10C, 32'h400, 1, 0);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++; if (branch_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL branch_cnt_sat got=%h exp=ffffffff", branch_cnt); end
      checks++; if (mispredict_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL misp_cnt_sat got=%h exp=ffffffff", mispredict_cnt); end
   endtask

   // Reset falls mid-cycle with a pending taken update at 0x100 (entry 0 = 2).
   task automatic test_async_reset();
      @(negedge clk);
      idle_inputs();
      drive_id(32'h100, 32'h40, 0);
      drive_ex(32'h100, 32'h140, 1, 1);
      #1;
      checks++; if (id_pred_taken !== 1'b1) begin errors++; $display("FAIL pre_reset_pred got=%b exp=1", id_pred_taken); end
      #1;
      rst_n = 0;
      #1;
      checks++; if (id_pred_taken !== 1'b0) begin errors++; $display("FAIL async_reset_pred got=%b exp=0", id_pred_taken); end
      checks++; if (branch_cnt !== 32'd0 || mispredict_cnt !== 32'd0) begin errors++; $display("FAIL async_reset_counts got=%h/%h exp=0/0", branch_cnt, mispredict_cnt); end
      @(negedge clk);
      rst_n = 1;
      idle_inputs();
      drive_id(32'h100, 32'h40, 0);
      #1;
      checks++; if (id_pred_taken !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL post_reset got=%b/%b exp=0/0", id_pred_taken, redirect_valid); end
      @(negedge clk);
      idle_inputs();
      drive_ex(32'h100, 32'h140, 0, 1);
      @(negedge clk);
      idle_inputs();
      drive_id(32'h100, 32'h40, 0);
      #1;
      checks++; if (id_pred_taken !== 1'b1) begin errors++; $display("FAIL post_reset_train got=%b exp=1", id_pred_taken); end
      checks++; if (branch_cnt !== 32'd1 || mispredict_cnt !== 32'd1) begin errors++; $display("FAIL post_reset_counts got=%0d/%0d exp=1/1", branch_cnt, mispredict_cnt); end
   endtask

   initial begin
      test_reset();
      test_train();
      test_priority();
      test_stall();
      test_same_index();
      test_non_branch();
      test_stat_saturation();
      test_async_reset();
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch prediction and redirect controller for the five-stage pipeline.
- Holds a table of 2-bit saturating counters and predicts conditional branches in ID.
- Compares each prediction with the outcome resolved in EX, then issues PC redirects and pipeline flushes.
- Updates the counters from EX outcomes and keeps saturating branch and mispredict statistics.
- Sits between the decoder/ID stage, the EX-stage branch-decision unit and the fetch PC mux.

## Interface
Parameters:
- XLEN, 32, datapath and PC width
- BHT_ENTRIES, 64, number of counters; must be a power of 2, minimum 4
- IDX_W, $clog2(BHT_ENTRIES), derived local parameter

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- id_valid  in  1  ID holds a valid instruction
- id_branch  in  1  decoder flags a conditional branch
- id_stall  in  1  ID is held this cycle
- id_pc  in  XLEN  PC of the ID instruction
- id_imm  in  XLEN  sign-extended B-immediate
- id_pred_taken  out  1  prediction, carried down the pipe to EX
- ex_valid  in  1  EX holds a valid instruction; high exactly one cycle per instruction
- ex_branch  in  1  EX instruction is a conditional branch
- ex_pred_taken  in  1  prediction carried from ID
- ex_take_branch  in  1  resolved outcome from the branch-decision unit
- ex_pc  in  XLEN  PC of the EX instruction
- ex_target  in  XLEN  resolved branch target
- redirect_valid  out  1  fetch must load redirect_pc
- redirect_pc  out  XLEN  new fetch PC
- flush_if_id  out  1  squash the IF/ID register
- flush_id_ex  out  1  squash the ID/EX register
- branch_cnt  out  32  resolved branches seen
- mispredict_cnt  out  32  mispredictions seen

## Operation
Index and prediction:
- Index = pc[IDX_W+1:2] for both the lookup and the update.
- Counter encoding: 0 = strong not-taken, 1 = weak not-taken, 2 = weak taken, 3 = strong taken. Predict taken when counter[1] is 1.
- id_pred_taken = id_valid & id_branch & bht[id_idx][1]. It is computed combinationally and is valid even while stalled.

ID redirect:
- Fires when id_pred_taken & !id_stall.
- Asserts redirect_valid, sets redirect_pc = id_pc + id_imm (mod 2^XLEN) and asserts flush_if_id.

EX mispredict:
- Condition: mispredict = ex_valid & ex_branch & (ex_take_branch != ex_pred_taken).
- Actions: assert redirect_valid and flush both flush_if_id and flush_id_ex.
- Target: redirect_pc = ex_take_branch ? ex_target : ex_pc + 4 (mod 2^XLEN).

Priority:
- An EX mispredict overrides an ID redirect in the same cycle.
- The ID prediction in that cycle is discarded; flush_id_ex squashes it.

Counter update, on the clock edge when ex_valid & ex_branch:
- Taken: increment, saturating at 3.
- Not taken: decrement, saturating at 0.
- All other entries hold.

Statistics:
- On ex_valid & ex_branch, branch_cnt increments.
- On mispredict, mispredict_cnt also increments.
- Both saturate at 32'hFFFF_FFFF.
- Non-branch instructions (ex_branch = 0) never redirect, update or count.

## Timing
Reset:
- rst_n low asynchronously sets every BHT entry to 1 (weak not-taken) and clears both counters.
- Combinational outputs depend on the inputs only. With the reset table, id_pred_taken = 0, so no ID redirect occurs after reset.

Latency:
- Prediction, redirect and flush are combinational in the same cycle as their inputs (0-cycle latency).
- Cost of a predicted-taken branch: 1 bubble.
- Cost of a mispredict: 2 bubbles.

Same-index read/write in one cycle:
- An ID lookup at the index EX is updating reads the pre-update value; there is no bypass.
- The new value is visible from the next cycle.

Stall:
- While id_stall is high, no ID redirect is issued.
- The redirect is issued exactly once, in the cycle the instruction leaves ID.
- EX resolution and updates are unaffected by id_stall.

Reset mid-operation: in-flight updates are lost. The table and counters return to their reset values in the same cycle rst_n falls.

## Structure
Package branch_pkg holds:
- typedef bht_cnt_t (logic [1:0])
- constants BHT_SNT = 0, BHT_WNT = 1, BHT_WT = 2, BHT_ST = 3
- function sat_update(cnt, taken)

Sub-module bht_table:
- Counter array with async reset, one combinational read port (ID) and one synchronous write port (EX).
- Instantiated once inside branch_ctrl.
- The statistics counters stay inline.

## Test plan
- Reset, then id_valid = id_branch = 1, id_pc = 0x100, id_imm = 0x40 → id_pred_taken = 0, redirect_valid = 0, both counters 0.
- Branch at PC 0x100 resolved taken twice in EX (ex_pred_taken = 0) → two mispredicts, redirect_pc = ex_target; next ID lookup of 0x100 → id_pred_taken = 1, redirect_pc = 0x140, flush_if_id = 1, flush_id_ex = 0.
- Same cycle: ID predicted-taken redirect plus EX mispredict, not taken, ex_pc = 0x200 → redirect_pc = 0x204, both flushes high.
- ID predicted-taken with id_stall high for 3 cycles → no redirect during the stall; exactly one redirect the cycle id_stall drops.
- EX update and ID lookup at the same index in one cycle → ID sees the old counter; the following cycle sees the saturated new one; counter stays 3 after repeated taken outcomes.
- Preload mispredict_cnt near saturation via 2^32 forced events, or force the register → it holds 0xFFFF_FFFF. Assert rst_n mid-run → all entries return to 1 and counters to 0 asynchronously.
